// File: rtl/lockstep_cmp_pkg.sv
// Shared constants, first-failure capture record and the voting helper for lockstep_cmp.
package lockstep_cmp_pkg;

  localparam int unsigned MAX_LANES  = 4;
  localparam int unsigned MAX_DELAY  = 7;
  localparam int unsigned MAX_WIDTH  = 64;
  localparam int unsigned MAX_CNT_W  = 32;
  localparam int unsigned LANE_IDX_W = 2;

  // First-failure record; fields are sized for the largest supported configuration
  // and the top truncates them to its own WIDTH / CNT_W.
  typedef struct packed {
    logic [LANE_IDX_W-1:0] lane;
    logic [MAX_WIDTH-1:0]  diff;
    logic [MAX_CNT_W-1:0]  cycle;
  } first_cap_t;

  // Majority of the included bits; an even split resolves to the tie value.
  function automatic logic majority(input logic [MAX_LANES-1:0] bits,
                                    input logic [MAX_LANES-1:0] incl,
                                    input logic                 tie);
    int unsigned ones;
    int unsigned cnt;
    ones = 0;
    cnt  = 0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (incl[i]) begin
        cnt = cnt + 1;
        if (bits[i]) ones = ones + 1;
      end
    end
    if (2 * ones > cnt)      return 1'b1;
    else if (2 * ones < cnt) return 1'b0;
    else                     return tie;
  endfunction

endpackage

// File: rtl/lockstep_cmp_delay.sv
// Reference-lane delay line: DEPTH-stage shift register, pure wire when DEPTH is 0.
module lockstep_cmp_delay #(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk;
    assign unused_clk = clk_i ^ rst_ni;
    assign q_o        = d_i;
  end else begin : g_shift
    logic [W-1:0] stage_q [DEPTH];

    // Shift the reference sample one stage per cycle; all stages clear on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/lockstep_cmp.sv
// Lockstep checker: compares a delayed reference lane against N-1 staggered copies.
// Optional majority voter enabled by defining LOCKSTEP_CMP_VOTE_EN.
module lockstep_cmp
  import lockstep_cmp_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned DELAY     = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic                       clear_i,
  input  logic [WIDTH-1:0]           mask_i,
  input  logic [NUM_LANES-1:0]       lane_valid_i,
  input  logic [NUM_LANES*WIDTH-1:0] lane_data_i,
  output logic                       armed_o,
  output logic                       mismatch_o,
  output logic [NUM_LANES-2:0]       mis_lanes_o,
  output logic                       sticky_o,
  output logic [CNT_W-1:0]           err_cnt_o,
  output logic [1:0]                 first_lane_o,
  output logic [WIDTH-1:0]           first_diff_o,
  output logic [CNT_W-1:0]           first_cycle_o
`ifdef LOCKSTEP_CMP_VOTE_EN
  ,
  output logic [WIDTH-1:0]           voted_o,
  output logic                       voted_valid_o
`endif
);

  localparam int unsigned ARM_W      = 4;
  localparam logic [ARM_W-1:0] ARM_TARGET = ARM_W'(DELAY + 1);

  // Reference lane after alignment
  logic [WIDTH-1:0] ref_data_dly;
  logic             ref_valid_dly;

  // Arming
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             armed_q, armed_d;

  // Compare results
  logic [WIDTH-1:0]     diff_c [NUM_LANES-1];
  logic [NUM_LANES-2:0] vld_both_c;
  logic [NUM_LANES-2:0] mis_c;
  logic                 any_mis_c;
  logic [LANE_IDX_W-1:0] sel_lane_c;
  logic [WIDTH-1:0]     sel_diff_c;
  logic                 sel_found_c;

  // Status and capture
  logic                 mismatch_q;
  logic [NUM_LANES-2:0] mis_lanes_q;
  logic                 sticky_q, sticky_d;
  logic [CNT_W-1:0]     err_q, err_d;
  logic [CNT_W-1:0]     cyc_q, cyc_d;
  first_cap_t           first_q, first_d;
  logic                 unused_cap;

  lockstep_cmp_delay #(
    .W     (WIDTH + 1),
    .DEPTH (DELAY)
  ) u_ref_dly (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    ({lane_valid_i[0], lane_data_i[WIDTH-1:0]}),
    .q_o    ({ref_valid_dly, ref_data_dly})
  );

  // Arm after DELAY+1 consecutive enabled cycles so the delay line holds live data.
  always_comb begin
    arm_cnt_d = '0;
    armed_d   = 1'b0;
    if (en_i) begin
      arm_cnt_d = (arm_cnt_q == ARM_TARGET) ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
      armed_d   = (arm_cnt_d == ARM_TARGET);
    end
  end

  // Per-lane masked compare against the aligned reference.
  always_comb begin
    for (int unsigned k = 1; k < NUM_LANES; k++) begin
      diff_c[k-1]     = (ref_data_dly ^ lane_data_i[k*WIDTH +: WIDTH]) & ~mask_i;
      vld_both_c[k-1] = ref_valid_dly & lane_valid_i[k];
      mis_c[k-1]      = armed_q & ((ref_valid_dly != lane_valid_i[k]) |
                                   (vld_both_c[k-1] & (|diff_c[k-1])));
    end
  end

  assign any_mis_c = |mis_c;

  // Lowest mismatching lane and its difference; a valid-only mismatch reports no diff bits.
  always_comb begin
    sel_found_c = 1'b0;
    sel_lane_c  = '0;
    sel_diff_c  = '0;
    for (int unsigned k = 1; k < NUM_LANES; k++) begin
      if (mis_c[k-1] && !sel_found_c) begin
        sel_found_c = 1'b1;
        sel_lane_c  = LANE_IDX_W'(k);
        sel_diff_c  = vld_both_c[k-1] ? diff_c[k-1] : '0;
      end
    end
  end

  // Cycle counter, sticky flag, saturating error count and first-failure capture.
  always_comb begin
    cyc_d    = '0;
    sticky_d = sticky_q;
    err_d    = err_q;
    first_d  = first_q;
    if (armed_q) begin
      cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
    end
    if (clear_i) begin
      sticky_d = 1'b0;
      err_d    = '0;
      first_d  = '0;
    end else if (any_mis_c) begin
      sticky_d = 1'b1;
      if (err_q != '1) err_d = err_q + CNT_W'(1);
      if (!sticky_q) begin
        first_d.lane  = sel_lane_c;
        first_d.diff  = MAX_WIDTH'(sel_diff_c);
        first_d.cycle = MAX_CNT_W'(cyc_q);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      arm_cnt_q   <= '0;
      armed_q     <= 1'b0;
      mismatch_q  <= 1'b0;
      mis_lanes_q <= '0;
      sticky_q    <= 1'b0;
      err_q       <= '0;
      cyc_q       <= '0;
      first_q     <= '0;
    end else begin
      arm_cnt_q   <= arm_cnt_d;
      armed_q     <= armed_d;
      mismatch_q  <= any_mis_c;
      mis_lanes_q <= mis_c;
      sticky_q    <= sticky_d;
      err_q       <= err_d;
      cyc_q       <= cyc_d;
      first_q     <= first_d;
    end
  end

  assign unused_cap    = ^first_q;
  assign armed_o       = armed_q;
  assign mismatch_o    = mismatch_q;
  assign mis_lanes_o   = mis_lanes_q;
  assign sticky_o      = sticky_q;
  assign err_cnt_o     = err_q;
  assign first_lane_o  = first_q.lane;
  assign first_diff_o  = first_q.diff[WIDTH-1:0];
  assign first_cycle_o = first_q.cycle[CNT_W-1:0];

`ifdef LOCKSTEP_CMP_VOTE_EN
  localparam logic [MAX_LANES-1:0] LANE_PRESENT = MAX_LANES'((1 << NUM_LANES) - 1);

  logic [MAX_LANES-1:0] vote_vld_c;
  logic [MAX_LANES-1:0] vote_bits_c;
  logic [WIDTH-1:0]     voted_d;
  logic                 voted_valid_d;
  logic [WIDTH-1:0]     voted_q;
  logic                 voted_valid_q;

  // Bitwise majority over valid lanes; even splits follow the aligned reference.
  always_comb begin
    vote_vld_c  = '0;
    vote_bits_c = '0;
    voted_d     = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      vote_vld_c[k] = (k == 0) ? ref_valid_dly : lane_valid_i[k];
    end
    voted_valid_d = majority(vote_vld_c, LANE_PRESENT, ref_valid_dly);
    for (int unsigned b = 0; b < WIDTH; b++) begin
      vote_bits_c = '0;
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
        vote_bits_c[k] = (k == 0) ? ref_data_dly[b] : lane_data_i[k*WIDTH + b];
      end
      voted_d[b] = majority(vote_bits_c, vote_vld_c, ref_data_dly[b]);
    end
  end

  // Voter output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      voted_q       <= '0;
      voted_valid_q <= 1'b0;
    end else begin
      voted_q       <= voted_d;
      voted_valid_q <= voted_valid_d;
    end
  end

  assign voted_o       = voted_q;
  assign voted_valid_o = voted_valid_q;
`endif

endmodule

// File: tb/tb_lockstep_cmp.sv
// Directed bench for lockstep_cmp: a 2-lane/DELAY=2 instance and a 3-lane/DELAY=0/CNT_W=4 instance.
module tb_lockstep_cmp;

  logic clk;
  logic rst_n;

  // Instance A: WIDTH=32, NUM_LANES=2, DELAY=2, CNT_W=16
  logic        a_en, a_clr;
  logic [31:0] a_mask;
  logic [1:0]  a_vld;
  logic [63:0] a_data;
  logic        a_armed, a_mis, a_sticky;
  logic [0:0]  a_lanes;
  logic [15:0] a_err, a_fcyc;
  logic [1:0]  a_flane;
  logic [31:0] a_fdiff;

  // Instance B: WIDTH=32, NUM_LANES=3, DELAY=0, CNT_W=4
  logic        b_en, b_clr;
  logic [31:0] b_mask;
  logic [2:0]  b_vld;
  logic [95:0] b_data;
  logic        b_armed, b_mis, b_sticky;
  logic [1:0]  b_lanes;
  logic [3:0]  b_err, b_fcyc;
  logic [1:0]  b_flane;
  logic [31:0] b_fdiff;

`ifdef LOCKSTEP_CMP_VOTE_EN
  logic [31:0] a_voted, b_voted;
  logic        a_vv, b_vv;
`endif

  int total = 0;
  int bad   = 0;

  lockstep_cmp #(.WIDTH(32), .NUM_LANES(2), .DELAY(2), .CNT_W(16)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(a_en), .clear_i(a_clr), .mask_i(a_mask),
    .lane_valid_i(a_vld), .lane_data_i(a_data), .armed_o(a_armed), .mismatch_o(a_mis),
    .mis_lanes_o(a_lanes), .sticky_o(a_sticky), .err_cnt_o(a_err), .first_lane_o(a_flane),
    .first_diff_o(a_fdiff), .first_cycle_o(a_fcyc)
`ifdef LOCKSTEP_CMP_VOTE_EN
    , .voted_o(a_voted), .voted_valid_o(a_vv)
`endif
  );

  lockstep_cmp #(.WIDTH(32), .NUM_LANES(3), .DELAY(0), .CNT_W(4)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(b_en), .clear_i(b_clr), .mask_i(b_mask),
    .lane_valid_i(b_vld), .lane_data_i(b_data), .armed_o(b_armed), .mismatch_o(b_mis),
    .mis_lanes_o(b_lanes), .sticky_o(b_sticky), .err_cnt_o(b_err), .first_lane_o(b_flane),
    .first_diff_o(b_fdiff), .first_cycle_o(b_fcyc)
`ifdef LOCKSTEP_CMP_VOTE_EN
    , .voted_o(b_voted), .voted_valid_o(b_vv)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lane-0 payload stream for instance A; lane 1 replays it two cycles later.
  function automatic logic [31:0] dat(input int n);
    return 32'hC0DE_0000 + 32'(n);
  endfunction

  // Drive one cycle of instance A (captured at the next posedge), then move to the next negedge.
  task automatic a_step(input int n, input logic [31:0] flip, input logic l1v,
                        input logic en, input logic clr, input logic [31:0] mask);
    a_en   = en;
    a_clr  = clr;
    a_mask = mask;
    a_vld  = {l1v, 1'b1};
    a_data = {dat(n - 2) ^ flip, dat(n)};
    @(negedge clk);
  endtask

  task automatic b_step(input logic en, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [2:0] v);
    b_en   = en;
    b_clr  = 1'b0;
    b_mask = '0;
    b_vld  = v;
    b_data = {d2, d1, d0};
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    a_en = 0; a_clr = 0; a_mask = '0; a_vld = '0; a_data = '0;
    b_en = 0; b_clr = 0; b_mask = '0; b_vld = '0; b_data = '0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_armed",  a_armed,  0);
    check("rst_mis",    a_mis,    0);
    check("rst_lanes",  a_lanes,  0);
    check("rst_sticky", a_sticky, 0);
    check("rst_err",    a_err,    0);
    check("rst_flane",  a_flane,  0);
    check("rst_fdiff",  a_fdiff,  0);
    check("rst_fcyc",   a_fcyc,   0);
    check("rst_b_err",  b_err,    0);
`ifdef LOCKSTEP_CMP_VOTE_EN
    check("rst_voted",  a_voted,  0);
    check("rst_vv",     a_vv,     0);
`endif
    rst_n = 1'b1;

    // Aligned lanes: arms at cycle 3, no mismatches
    for (int n = 0; n <= 13; n++) begin
      if (n <= 3) check($sformatf("armed_c%0d", n), a_armed, (n == 3) ? 1 : 0);
      check($sformatf("nomis_c%0d", n), a_mis, 0);
      check($sformatf("noerr_c%0d", n), a_err, 0);
      a_step(n, (n == 13) ? 32'h20 : 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    end

    // Bit 5 flipped at armed cycle 10 (cycle 13)
    check("flip_mis",    a_mis,    1);
    check("flip_lanes",  a_lanes,  1);
    check("flip_sticky", a_sticky, 1);
    check("flip_flane",  a_flane,  1);
    check("flip_fdiff",  a_fdiff,  32'h20);
    check("flip_fcyc",   a_fcyc,   10);
    check("flip_err",    a_err,    1);
    a_step(14, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("pulse_end",   a_mis,    0);
    check("sticky_hold", a_sticky, 1);
    check("err_hold",    a_err,    1);
    a_step(15, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Masked flip is ignored
    a_step(16, 32'h20, 1'b1, 1'b1, 1'b0, 32'h20);
    check("mask_mis", a_mis, 0);
    check("mask_err", a_err, 1);
    a_step(17, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Plain clear
    a_step(18, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0);
    check("clr_sticky", a_sticky, 0);
    check("clr_err",    a_err,    0);
    check("clr_fcyc",   a_fcyc,   0);
    check("clr_flane",  a_flane,  0);
    check("clr_fdiff",  a_fdiff,  0);
    a_step(19, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Valid-only mismatch: lane 1 invalid (data also differs) while reference valid
    a_step(20, 32'h20, 1'b0, 1'b1, 1'b0, 32'h0);
    check("vld_mis",   a_mis,   1);
    check("vld_flane", a_flane, 1);
    check("vld_fdiff", a_fdiff, 0);
    check("vld_fcyc",  a_fcyc,  17);
    check("vld_err",   a_err,   1);
    a_step(21, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Clear coincident with a mismatch: reported but not counted
    a_step(22, 32'h20, 1'b1, 1'b1, 1'b1, 32'h0);
    check("clrmis_mis",    a_mis,    1);
    check("clrmis_sticky", a_sticky, 0);
    check("clrmis_err",    a_err,    0);
    check("clrmis_fcyc",   a_fcyc,   0);
    for (int n = 23; n <= 32; n++) a_step(n, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    a_step(33, 32'h20, 1'b1, 1'b1, 1'b0, 32'h0);
    check("c30_fcyc",   a_fcyc,   30);
    check("c30_err",    a_err,    1);
    check("c30_sticky", a_sticky, 1);
    check("c30_mis",    a_mis,    1);
    a_step(34, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Disarm keeps sticky state and capture
    a_step(35, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("dis_armed",  a_armed,  0);
    check("dis_sticky", a_sticky, 1);
    check("dis_fcyc",   a_fcyc,   30);
    a_step(36, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);

    // Instance B: 3 lanes, no delay, 4-bit counters
    for (int m = 0; m <= 25; m++) begin
      if (m == 0) check("b_armed0", b_armed, 0);
      if (m == 1) check("b_armed1", b_armed, 1);
      if (m == 4) check("b_nomis",  b_mis,   0);
      if (m == 5) begin
        check("b_mis",   b_mis,   1);
        check("b_lanes", b_lanes, 2'b10);
        check("b_flane", b_flane, 2);
        check("b_fdiff", b_fdiff, 32'hEDCBA987);
        check("b_fcyc",  b_fcyc,  3);
        check("b_err1",  b_err,   1);
`ifdef LOCKSTEP_CMP_VOTE_EN
        check("b_voted", b_voted, 32'h12345678);
        check("b_vv",    b_vv,    1);
`endif
      end
      if (m == 19) check("b_err15",  b_err, 15);
      if (m == 24) begin
        check("b_errsat", b_err,    15);
        check("b_fcyc_h", b_fcyc,   3);
        check("b_sticky", b_sticky, 1);
      end
`ifdef LOCKSTEP_CMP_VOTE_EN
      if (m == 25) begin
        check("b_tie_voted", b_voted, 32'h0000FFFF);
        check("b_tie_vv",    b_vv,    1);
      end
`endif
      if (m < 4)
        b_step(1'b1, 32'h12345678, 32'h12345678, 32'h12345678, 3'b111);
      else if (m < 24)
        b_step(1'b1, 32'h12345678, 32'h12345678, 32'hFFFFFFFF, 3'b111);
      else
        b_step(1'b1, 32'h0000FFFF, 32'hAAAAAAAA, 32'hFFFF0000, 3'b101);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lockstep_cmp.md
Name: lockstep_cmp

Overview:
- Parametrised lockstep checker for N redundant copies of a core's output bundle.
- Lane 0 is the reference. Its outputs are delayed DELAY cycles so they line up with lanes 1..N-1, which run time-staggered behind it.
- Each delayed reference sample is compared against every other lane, with a per-bit exclusion mask.
- Reports per-cycle mismatches, a sticky error flag, a saturating error count and a first-failure capture. Sits beside a dual/multi-core instantiation wrapper.

Parameters:
WIDTH, 32, bits per lane output bundle
NUM_LANES, 2, number of redundant copies (2..4)
DELAY, 0, reference lag in cycles (0..7)
CNT_W, 16, width of error and cycle counters

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
en_i  in  1  comparison enable
clear_i  in  1  clears sticky, counters, capture
mask_i  in  WIDTH  1 = bit excluded from compare
lane_valid_i  in  NUM_LANES  per-lane sample valid
lane_data_i  in  NUM_LANES*WIDTH  lane k at [k*WIDTH +: WIDTH]
armed_o  out  1  comparison active
mismatch_o  out  1  registered per-cycle mismatch pulse
mis_lanes_o  out  NUM_LANES-1  bit k-1 = lane k mismatched this cycle
sticky_o  out  1  latched error
err_cnt_o  out  CNT_W  mismatching cycles, saturating
first_lane_o  out  2  lane index of first mismatch
first_diff_o  out  WIDTH  masked XOR of first mismatch
first_cycle_o  out  CNT_W  armed-cycle index of first mismatch

Behaviour:
- Reset (async, rst_ni=0): every output and internal register is 0, including delay-line contents.
- Delay line: lane 0 data and valid pass through DELAY registers. DELAY=0 is a pure wire.
- Arming: an arm counter counts consecutive cycles with en_i=1. armed_o=1 once en_i has been high for DELAY+1 cycles.
- Disarming: en_i=0 zeroes the arm counter and clears armed_o the next cycle. Sticky state and capture are retained.
- Compare, combinational, for each lane k≥1:
  - diff_k = (ref_d ^ lane_k) & ~mask_i
  - mis_k = armed & ((ref_valid_d != lane_valid_k) | (ref_valid_d & lane_valid_k & |diff_k))
  - Both lanes invalid: no mismatch.
- Latency: mis_lanes_o and mismatch_o (= OR of mis_k) are registered, one cycle after the sample.
- Cycle counter: increments each armed cycle, saturates at all-ones, resets to 0 when disarmed.
- err_cnt_o: +1 per cycle with any mis_k; saturates at 2^CNT_W-1 and never wraps.
- sticky_o: set on any mis_k; held until clear_i or reset.
- First capture, loaded only when sticky is 0 and any mis_k:
  - first_lane_o = lowest mismatching k
  - first_diff_o = diff_k of that lane (0 if valid-only mismatch)
  - first_cycle_o = current cycle counter
- clear_i: has priority over a simultaneous mismatch. Sticky, err_cnt_o and capture go to 0; that cycle's mismatch is not counted or captured. mismatch_o/mis_lanes_o still report it. Arm state is unaffected.
- mask_i and en_i are sampled every cycle with no hold requirement.

Optional Feature:
- Macro: LOCKSTEP_CMP_VOTE_EN.
- Defined: adds outputs voted_o (WIDTH) and voted_valid_o (1), registered with 1-cycle latency.
  - Inputs: delayed reference plus lanes 1..N-1.
  - voted_o: bitwise majority over the valid lanes.
  - voted_valid_o: majority of the valid bits.
  - Ties (even count) resolve to the delayed reference bit.
  - Reset value 0.
- Undefined: ports and logic absent. Compare behaviour is identical either way.

Decomposition:
- lockstep_cmp_pkg holds:
  - MAX_LANES=4 and MAX_DELAY=7 constants
  - first_cap_t struct (lane, diff, cycle)
  - majority function used by the vote logic
- Sub-module lockstep_cmp_delay: parametrised WIDTH+1-bit shift register with async reset, depth DELAY, DELAY=0 as a pass-through.

Test Plan:
- NUM_LANES=2, DELAY=2, lane1 = lane0 lagged 2 cycles, en_i=1 from cycle 0 -> armed_o=1 at cycle 3; mismatch_o never; err_cnt_o=0.
- Same setup, lane1 bit 5 flipped at armed cycle 10 -> mismatch_o pulses 1 cycle later; sticky_o=1; first_lane_o=1; first_diff_o=0x20; first_cycle_o=10; err_cnt_o=1.
- Same flip with mask_i=0x20 -> no mismatch. Then lane1 valid=0 while reference valid=1 -> mismatch with first_diff_o=0.
- CNT_W=4, 20 consecutive mismatching cycles -> err_cnt_o=15 and holds; first_cycle_o equals the first failing cycle.
- clear_i in the same cycle as a mismatch -> sticky_o=0, err_cnt_o=0 next cycle. Next mismatch at cycle 30 captures first_cycle_o=30.
- LOCKSTEP_CMP_VOTE_EN, NUM_LANES=3, DELAY=0, lanes 0 and 1 = 0x12345678, lane 2 = 0xFFFFFFFF -> voted_o=0x12345678; mis_lanes_o=2'b10.
